// File: rtl/ofm_write_buffer_pkg.sv
// Shared definitions for the OFM write buffer: geometry defaults, FSM encoding
// and the lane-mask helper.
package ofm_write_buffer_pkg;

    localparam int LANES            = 16;
    localparam int ELEM_W           = 16;
    localparam int ROW_W            = LANES * ELEM_W;
    localparam int OFM_RAM_SIZE_DEF = 692224;
    localparam int ADDR_W           = $clog2(OFM_RAM_SIZE_DEF);
    localparam int SIZE_W           = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Lane i is valid when i < size; sizes above LANES saturate to all ones.
    function automatic logic [LANES-1:0] mask_from_size(input logic [SIZE_W-1:0] size);
        logic [LANES-1:0] m;
        for (int i = 0; i < LANES; i++) begin
            m[i] = (i < int'(size));
        end
        return m;
    endfunction

endpackage

// File: rtl/ofm_sync_fifo.sv
// Synchronous FIFO with a registered head entry; level counts every stored
// entry including the one currently presented on rdata.
module ofm_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             head_valid;
    logic [WIDTH-1:0] head_q;
    logic             push_ok;
    logic             backlog;
    logic             load;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    // A pop in the same cycle frees a slot, so a push is accepted even when full.
    assign push_ok = push & (~full | pop);
    // Entries still waiting in the array behind the head register.
    assign backlog = (count != {{(LW-1){1'b0}}, head_valid});
    assign load    = backlog & (~head_valid | pop);

    assign rdata = head_q;
    assign valid = head_valid;
    assign level = count;

    // NOTE: the storage array is deliberately not reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_q     <= '0;
        end else begin
            // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                head_q     <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + 1'b1;
                head_valid <= 1'b1;
            end else if (pop) begin
                head_valid <= 1'b0;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ofm_write_buffer.sv
// Buffers accelerator OFM write bursts and re-issues them over valid/ready,
// tracking layer completion so the host only sees drained once all writes land.
module ofm_write_buffer
    import ofm_write_buffer_pkg::*;
#(
    parameter  int SYSTOLIC_SIZE = LANES,
    parameter  int DATA_WIDTH    = ELEM_W,
    parameter  int INOUT_WIDTH   = ROW_W,
    parameter  int OFM_RAM_SIZE  = OFM_RAM_SIZE_DEF,
    parameter  int FIFO_DEPTH    = 32,
    localparam int AW            = $clog2(OFM_RAM_SIZE),
    localparam int LW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     layer_start,
    input  logic                     layer_done,
    input  logic                     in_en,
    input  logic [AW-1:0]            in_addr,
    input  logic [INOUT_WIDTH-1:0]   in_data,
    input  logic [4:0]               in_size,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [AW-1:0]            out_addr,
    output logic [INOUT_WIDTH-1:0]   out_data,
    output logic [SYSTOLIC_SIZE-1:0] out_mask,
    output logic [LW-1:0]            level,
    output logic                     drained,
    output logic                     overflow,
    output logic [23:0]              write_count,
    output logic [15:0]              drop_count
);

    typedef struct packed {
        logic [AW-1:0]            addr;
        logic [INOUT_WIDTH-1:0]   data;
        logic [SYSTOLIC_SIZE-1:0] mask;
    } burst_t;

    burst_t in_burst;
    burst_t head;
    logic   handshake;
    logic   full;
    logic   empty;
    logic   dropped;
    state_t state_q;
    state_t state_d;

    always_comb begin
        in_burst.addr = in_addr;
        in_burst.mask = mask_from_size(in_size);
        for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
            in_burst.data[i*DATA_WIDTH +: DATA_WIDTH] =
                in_burst.mask[i] ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    ofm_sync_fifo #(
        .WIDTH ($bits(burst_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_en),
        .pop   (handshake),
        .wdata (in_burst),
        .rdata (head),
        .valid (out_valid),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign handshake = out_valid & out_ready;
    assign dropped   = in_en & full & ~handshake;
    assign out_addr  = head.addr;
    assign out_data  = head.data;
    assign out_mask  = head.mask;
    assign drained   = (state_q == ST_DONE);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (layer_start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:   if (layer_done) state_d = ST_FLUSH;
                ST_FLUSH: if (empty && !in_en) state_d = ST_DONE;
                ST_DONE:  if (in_en) state_d = ST_FLUSH;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A layer_start clears the layer statistics and takes precedence over same-cycle events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else if (layer_start) begin
            write_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (handshake) begin
                write_count <= write_count + 24'd1;
            end
            if (dropped) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ofm_write_buffer.sv
// Randomized self-checking bench for ofm_write_buffer against a queue-based
// reference model of the burst buffer and layer-tracking behaviour.
module tb_ofm_write_buffer;
    import ofm_write_buffer_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = ADDR_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          layer_start, layer_done, in_en, out_ready;
    logic [AW-1:0] in_addr;
    logic [255:0]  in_data;
    logic [4:0]    in_size;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [255:0]  out_data;
    logic [15:0]   out_mask;
    logic [5:0]    level;
    logic          drained, overflow;
    logic [23:0]   write_count;
    logic [15:0]   drop_count;

    always #5 clk = ~clk;

    ofm_write_buffer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .layer_start (layer_start),
        .layer_done  (layer_done),
        .in_en       (in_en),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .in_size     (in_size),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .out_mask    (out_mask),
        .level       (level),
        .drained     (drained),
        .overflow    (overflow),
        .write_count (write_count),
        .drop_count  (drop_count)
    );

    // Reference model: a queue of bursts, each stamped with the edge that stored it.
    typedef struct {
        logic [AW-1:0] addr;
        logic [255:0]  data;
        logic [15:0]   mask;
        int            t;
    } ent_t;
    typedef enum { M_IDLE, M_RUN, M_FLUSH, M_DONE } mst_t;

    ent_t        q[$];
    int          edge_n = 0;
    logic [23:0] m_wr = '0;
    logic [15:0] m_drop = '0;
    bit          m_ovf = 1'b0;
    mst_t        mst = M_IDLE;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // A burst becomes visible on the output one edge after it was stored.
    function automatic bit m_visible();
        return (q.size() > 0) && (q[0].t < edge_n);
    endfunction

    function automatic ent_t make_ent(input logic [AW-1:0] a, input logic [255:0] d,
                                      input logic [4:0] sz, input int t);
        ent_t e;
        int   n;
        n = (sz > 5'd16) ? 16 : int'(sz);
        e.addr = a;
        e.mask = (n == 16) ? 16'hFFFF : 16'((32'd1 << n) - 32'd1);
        e.data = '0;
        for (int i = 0; i < n; i++) e.data[i*16 +: 16] = d[i*16 +: 16];
        e.t = t;
        return e;
    endfunction

    function automatic logic [255:0] rand_row();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic compare_all();
        bit vis;
        vis = m_visible();
        check("out_valid", 256'(out_valid), 256'(vis));
        check("level", 256'(level), 256'(q.size()));
        check("drained", 256'(drained), 256'(mst == M_DONE));
        check("overflow", 256'(overflow), 256'(m_ovf));
        check("write_count", 256'(write_count), 256'(m_wr));
        check("drop_count", 256'(drop_count), 256'(m_drop));
        if (vis) begin
            check("out_addr", 256'(out_addr), 256'(q[0].addr));
            check("out_data", out_data, q[0].data);
            check("out_mask", 256'(out_mask), 256'(q[0].mask));
        end
    endtask

    task automatic cyc(input bit en, input logic [AW-1:0] a, input logic [255:0] d,
                       input logic [4:0] sz, input bit rdy, input bit ls, input bit ld);
        bit hs;
        int lvl0;
        in_en = en; in_addr = a; in_data = d; in_size = sz;
        out_ready = rdy; layer_start = ls; layer_done = ld;
        hs   = m_visible() && rdy;
        lvl0 = q.size();
        @(posedge clk);
        #1;
        edge_n++;
        if (hs) begin
            void'(q.pop_front());
            m_wr = m_wr + 24'd1;
        end
        if (en) begin
            if (lvl0 < DEPTH || hs) begin
                q.push_back(make_ent(a, d, sz, edge_n));
            end else begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
        end
        if (ls) begin
            m_wr = '0; m_drop = '0; m_ovf = 1'b0;
            mst = M_RUN;
        end else begin
            case (mst)
                M_RUN:   if (ld) mst = M_FLUSH;
                M_FLUSH: if (lvl0 == 0 && !en) mst = M_DONE;
                M_DONE:  if (en) mst = M_FLUSH;
                default: ;
            endcase
        end
        compare_all();
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, '0, '0, 5'd0, rdy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_en = 1'b0; in_addr = '0; in_data = '0; in_size = '0;
        out_ready = 1'b0; layer_start = 1'b0; layer_done = 1'b0;
        @(posedge clk);
        #1;
        edge_n++;
        q.delete();
        m_wr = '0; m_drop = '0; m_ovf = 1'b0; mst = M_IDLE;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_addr", 256'(out_addr), 256'(0));
        check("rst_out_data", out_data, 256'(0));
        check("rst_out_mask", 256'(out_mask), 256'(0));
        check("rst_level", 256'(level), 256'(0));
        check("rst_drained", 256'(drained), 256'(0));
        check("rst_overflow", 256'(overflow), 256'(0));
        check("rst_write_count", 256'(write_count), 256'(0));
        check("rst_drop_count", 256'(drop_count), 256'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        logic [255:0] ones;
        logic [255:0] five_lanes;
        ones       = '1;
        five_lanes = (256'd1 << 80) - 256'd1;

        do_reset();
        do_reset();

        // Single full-width burst.
        cyc(1'b1, AW'('h100), rand_row(), 5'd16, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("single_write_count", 256'(write_count), 256'(1));

        // Partial row: only the low five lanes survive.
        cyc(1'b1, AW'('h200), ones, 5'd5, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("partial_mask", 256'(out_mask), 256'(16'h001F));
        check("partial_data", out_data, five_lanes);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: 33 pushes into a 32-deep buffer.
        for (int i = 0; i < 33; i++) begin
            cyc(1'b1, AW'(i), rand_row(), 5'($urandom_range(0, 20)), 1'b0, 1'b0, 1'b0);
        end
        check("bp_level", 256'(level), 256'(32));
        check("bp_drop_count", 256'(drop_count), 256'(1));
        idle(1'b0);
        check("bp_head_stable", 256'(out_addr), 256'(0));
        // Simultaneous push and pop while full: nothing dropped.
        cyc(1'b1, AW'(100), rand_row(), 5'd16, 1'b1, 1'b0, 1'b0);
        check("full_pushpop_level", 256'(level), 256'(32));
        check("full_pushpop_drops", 256'(drop_count), 256'(1));
        for (int i = 0; i < 40; i++) idle(1'b1);

        // Layer flow with 50% downstream readiness.
        cyc(1'b0, '0, '0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, AW'(1000 + i), rand_row(), 5'($urandom_range(0, 16)),
                1'($urandom % 2), 1'b0, 1'b0);
        end
        cyc(1'b0, '0, '0, 5'd0, 1'($urandom % 2), 1'b0, 1'b1);
        for (int k = 0; k < 200 && drained !== 1'b1; k++) idle(1'($urandom % 2));
        check("layer_drained", 256'(drained), 256'(1));
        check("layer_write_count", 256'(write_count), 256'(10));
        check("layer_level", 256'(level), 256'(0));
        cyc(1'b0, '0, '0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("layer_restart_count", 256'(write_count), 256'(0));

        // Random traffic with varying downstream pressure and layer events.
        for (int i = 0; i < 1500; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 150) % 2 == 0) ? 80 : 25;
            cyc(1'($urandom % 2), AW'($urandom), rand_row(), 5'($urandom_range(0, 20)),
                ($urandom % 100) < rdy_pct, ($urandom % 100) == 0, ($urandom % 40) == 0);
        end

        // Reset with seven bursts pending.
        for (int i = 0; i < 40; i++) idle(1'b1);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, AW'(50 + i), rand_row(), 5'd16, 1'b0, 1'b0, 1'b0);
        end
        check("pre_reset_level", 256'(level), 256'(7));
        do_reset();
        idle(1'b1);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
